// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule
//   Sequential SHA-256 message-schedule expander. A 512-bit block is loaded
//   into a 16-word sliding window. The module then streams W[0]..W[ROUNDS-1]
//   to the round stage, one word per accepted valid/ready handshake. Each
//   accepted word shifts the window down by one and appends the next
//   expanded word.
//
// Ports
//   clk       system clock, all state on the rising edge
//   rst       synchronous, active-high reset (priority over all inputs)
//   start     one-cycle load request, honoured only in IDLE
//   block_in  message block, W[0] = block_in[511:480]
//   w_out     current schedule word W[w_idx]
//   w_idx     index of w_out
//   w_valid   w_out/w_idx valid
//   w_ready   consumer accept
//   busy      high while words are being streamed
//   done      one-cycle pulse after the last word is accepted
module sha256_msg_schedule #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [511:0] block_in,
  output logic [31:0]  w_out,
  output logic [5:0]   w_idx,
  output logic         w_valid,
  input  logic         w_ready,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [5:0] LAST = 6'(ROUNDS - 1);

  state_t      state;
  logic [31:0] win [16];
  logic [5:0]  t;

  // Fixed rotates and shifts are wiring only. ROTR n moves bit k to
  // bit (k-n) mod 32, and SHR zero-fills from the top.
  logic [31:0] x0, x1, s0, s1, w_next;
  logic        hs;

  assign x0 = win[1];
  assign x1 = win[14];
  assign s0 = {x0[6:0],  x0[31:7]}  ^ {x0[17:0], x0[31:18]} ^ {3'b0,  x0[31:3]};
  assign s1 = {x1[16:0], x1[31:17]} ^ {x1[18:0], x1[31:19]} ^ {10'b0, x1[31:10]};

  // The window holds W[t..t+15]. The word appended after the shift is
  // W[t+16], so W[t-2] becomes win[14], W[t-7] becomes win[9], and so on.
  assign w_next = s1 + win[9] + s0 + win[0];

  assign hs    = w_valid && w_ready;
  assign w_out = win[0];
  assign w_idx = t;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      t       <= '0;
      w_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            for (int i = 0; i < 16; i++) win[i] <= block_in[511-32*i -: 32];
            t       <= '0;
            w_valid <= 1'b1;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (hs) begin
            // Expansion continues past ROUNDS-16. Those trailing words are
            // computed but never presented.
            for (int i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15] <= w_next;
            t       <= t + 6'd1;
            if (t == LAST) begin
              w_valid <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= FIN;
            end
          end
        end
        FIN: begin
          // A start during this cycle is dropped. The next block needs a
          // fresh request issued from IDLE.
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          w_valid <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
